// File: rtl/gf2m_iter_squarer.sv
// Iterated GF(2^m) squarer: c = a^(2^k) mod f, one squaring per clock.
// classic_squarer is the combinational bit-spread-and-reduce core it feeds back through.

module classic_squarer #(
  parameter int          M = 163,
  parameter logic [M-1:0] F = 163'hC9
) (
  input  logic [M-1:0] a,
  output logic [M-1:0] c
);

  // Full reduction polynomial including the x^M term, widened to the square's width.
  localparam logic [2*M-2:0] POLY = {{(M-2){1'b0}}, 1'b1, F};

  logic [2*M-2:0] t;

  always_comb begin
    t = '0;
    for (int i = 0; i < M; i++) begin
      t[2*i] = a[i];
    end
    for (int i = 2*M-2; i >= M; i--) begin
      if (t[i]) begin
        t = t ^ (POLY << (i - M));
      end
    end
    c = t[M-1:0];
  end

endmodule

module gf2m_iter_squarer #(
  parameter int           M  = 163,
  parameter logic [M-1:0] F  = 163'hC9,
  parameter int           KW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [M-1:0]  a,
  input  logic [KW-1:0] k,
  output logic          busy,
  output logic          done,
  output logic [M-1:0]  c
);

  // state  | meaning
  // IDLE   | waiting for start
  // RUN    | squaring r once per clock, cnt squarings left
  // DONE   | c valid, done high; a new start is accepted here too
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [KW-1:0] CNT_ONE = {{(KW-1){1'b0}}, 1'b1};

  logic [1:0]    state;
  logic [M-1:0]  r;
  logic [KW-1:0] cnt;
  logic [M-1:0]  r_sq;

  classic_squarer #(.M(M), .F(F)) u_sq (
    .a (r),
    .c (r_sq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      r     <= '0;
      cnt   <= '0;
      c     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          r   <= r_sq;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= S_DONE;
            c     <= r_sq;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a start; DONE falls back to IDLE otherwise.
          done <= 1'b0;
          if (start) begin
            r   <= a;
            cnt <= k;
            if (k != '0) begin
              state <= S_RUN;
              busy  <= 1'b1;
            end else begin
              state <= S_DONE;
              c     <= a;
              done  <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_iter_squarer.sv
// Directed bench for gf2m_iter_squarer with an expected-result queue and a
// shift-and-add GF(2^163) multiplier as the reference model.

module tb_gf2m_iter_squarer;

  localparam int           M  = 163;
  localparam int           KW = 8;
  localparam logic [M-1:0] F  = 163'hC9;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [M-1:0]  a;
  logic [KW-1:0] k;
  logic          busy;
  logic          done;
  logic [M-1:0]  c;

  int checks = 0;
  int errors = 0;
  logic [M-1:0] exp_q[$];
  logic [M-1:0] last_c;

  gf2m_iter_squarer #(.M(M), .F(F), .KW(KW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .k     (k),
    .busy  (busy),
    .done  (done),
    .c     (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [M-1:0] acc;
    acc = '0;
    for (int i = M-1; i >= 0; i--) begin
      acc = acc[M-1] ? ((acc << 1) ^ F) : (acc << 1);
      if (y[i]) acc = acc ^ x;
    end
    return acc;
  endfunction

  function automatic logic [M-1:0] pow2k(input logic [M-1:0] x, input int kk);
    logic [M-1:0] v;
    v = x;
    for (int i = 0; i < kk; i++) v = gf_mul(v, v);
    return v;
  endfunction

  task automatic check_vec(input string tag, input logic [M-1:0] obs, input logic [M-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs == expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Called at a negedge. chain=1 returns in the done cycle so the caller can
  // issue a back-to-back start; poke_at >= 0 pulses a bogus start during RUN.
  task automatic do_op(input logic [M-1:0] av, input logic [KW-1:0] kv,
                       input logic [M-1:0] expv, input bit chain, input int poke_at);
    int n;
    int busy_n;
    logic [M-1:0] want;
    exp_q.push_back(expv);
    start = 1'b1; a = av; k = kv;
    @(negedge clk);
    start = 1'b0; a = '0; k = '0;
    n = 0;
    busy_n = 0;
    while (done !== 1'b1 && n <= 300) begin
      if (busy === 1'b1) busy_n++;
      check_vec("c_hold_run", c, last_c);
      if (n == poke_at) begin
        start = 1'b1; a = av ^ 3; k = 1;
      end
      @(negedge clk);
      start = 1'b0; a = '0; k = '0;
      n++;
    end
    check_int("latency", n, int'(kv));
    check_int("busy_cycles", busy_n, int'(kv));
    check_bit("busy_at_done", busy, 1'b0);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      want = '0;
    end else begin
      want = exp_q.pop_front();
    end
    check_vec("result", c, want);
    last_c = want;
    if (!chain) begin
      @(negedge clk);
      check_bit("done_one_cycle", done, 1'b0);
      check_vec("c_hold_after", c, want);
    end
  endtask

  logic [M-1:0] rnd;
  logic [M-1:0] one;
  int done_cnt;

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; k = '0;
    last_c = '0;
    one = {{(M-1){1'b0}}, 1'b1};
    repeat (2) @(negedge clk);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    check_vec("reset_c", c, '0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(163'h1234, 8'd0, 163'h1234, 1'b0, -1);
    do_op(163'h2, 8'd1, 163'h4, 1'b0, -1);
    do_op(163'h2, 8'd7, one << 128, 1'b0, 2);
    do_op(one << 82, 8'd1, 163'h192, 1'b0, -1);
    do_op(163'h0FEDCBA987654321, 8'd163, 163'h0FEDCBA987654321, 1'b0, -1);

    do_op(163'h2, 8'd3, 163'h100, 1'b1, -1);
    do_op(163'h2, 8'd2, 163'h10, 1'b1, -1);
    do_op(163'h55, 8'd0, 163'h55, 1'b0, -1);

    rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_op(rnd, 8'd5, pow2k(rnd, 5), 1'b0, -1);
    rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_op(rnd, 8'd255, pow2k(rnd, 255), 1'b0, -1);

    start = 1'b1; a = 163'h2; k = 8'd100;
    @(negedge clk);
    start = 1'b0; a = '0; k = '0;
    repeat (10) @(negedge clk);
    check_bit("run_busy_before_reset", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_bit("async_reset_busy", busy, 1'b0);
    check_bit("async_reset_done", done, 1'b0);
    check_vec("async_reset_c", c, '0);
    @(negedge clk);
    rst_n = 1'b1;
    last_c = '0;
    done_cnt = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check_int("no_done_after_abort", done_cnt, 0);
    check_vec("c_zero_after_abort", c, '0);
    do_op(163'h2, 8'd1, 163'h4, 1'b0, -1);

    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
